// File: rtl/div_pkg.sv
// Shared constants, types and FSM states for the iterative signed divider.
package div_pkg;
  localparam int unsigned DW   = 32;
  localparam int unsigned QW   = 16;
  localparam int unsigned ITER = 32;
  localparam int unsigned CW   = $clog2(ITER);

  typedef logic [DW-1:0] dword_t;
  typedef logic [QW-1:0] hword_t;
  typedef logic [QW:0]   prem_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  typedef struct packed {
    hword_t q;
    hword_t r;
    logic   dz;
    logic   ovf;
  } result_t;
endpackage

// File: rtl/sign_mag.sv
// Two's-complement conditional negate; with neg_i = sign bit it yields |val_i|.
module sign_mag #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);
  assign res_o = neg_i ? W'(~val_i + 1'b1) : val_i;
endmodule

// File: rtl/nr_divider.sv
// Iterative signed 32/16 divider: restoring radix-2 on magnitudes, signs fixed up in a final cycle.
module nr_divider
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic [QW-1:0] q,
  output logic [QW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ovf
);
  state_e  state_q, state_d;
  dword_t  quot_q, quot_d;
  prem_t   prem_q, prem_d;
  hword_t  dvs_q, dvs_d;
  cnt_t    cnt_q, cnt_d;
  logic    qneg_q, qneg_d, rneg_q, rneg_d;
  result_t res_q, res_d;
  logic    busy_q, busy_d, done_q, done_d;

  dword_t  dvd_abs, quot_sgn;
  hword_t  dvs_abs, rem_sgn;
  prem_t   shifted, trial;
  logic    q_ovf;

  sign_mag #(.W(DW)) u_abs_dvd (.val_i(dividend), .neg_i(dividend[DW-1]), .res_o(dvd_abs));
  sign_mag #(.W(QW)) u_abs_dvs (.val_i(divisor), .neg_i(divisor[QW-1]), .res_o(dvs_abs));
  sign_mag #(.W(DW)) u_sgn_quo (.val_i(quot_q), .neg_i(qneg_q), .res_o(quot_sgn));
  sign_mag #(.W(QW)) u_sgn_rem (.val_i(prem_q[QW-1:0]), .neg_i(rneg_q), .res_o(rem_sgn));

  // Negative quotients may reach magnitude 2^15, positive ones only 2^15-1.
  assign q_ovf = qneg_q ? (quot_q > DW'(32'h0000_8000)) : (quot_q > DW'(32'h0000_7FFF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (divisor == '0) ? FIX : CALC;
      CALC:    if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    quot_d  = quot_q;
    prem_d  = prem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    // Dividend magnitude shifts out of quot_q MSB-first while quotient bits enter at the LSB.
    shifted = prem_t'({prem_q, quot_q[DW-1]});
    trial   = shifted - {1'b0, dvs_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          quot_d = dvd_abs;
          dvs_d  = dvs_abs;
          qneg_d = dividend[DW-1] ^ divisor[QW-1];
          rneg_d = dividend[DW-1];
          prem_d = '0;
          cnt_d  = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (!trial[QW]) begin
          prem_d = trial;
          quot_d = {quot_q[DW-2:0], 1'b1};
        end else begin
          prem_d = shifted;
          quot_d = {quot_q[DW-2:0], 1'b0};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (dvs_q == '0) begin
          res_d.q   = '0;
          res_d.r   = '0;
          res_d.dz  = 1'b1;
          res_d.ovf = 1'b0;
        end else begin
          res_d.q   = quot_sgn[QW-1:0];
          res_d.r   = rem_sgn;
          res_d.dz  = 1'b0;
          res_d.ovf = q_ovf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      prem_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      prem_q <= prem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      res_q  <= res_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign q    = res_q.q;
  assign r    = res_q.r;
  assign dz   = res_q.dz;
  assign ovf  = res_q.ovf;
  assign busy = busy_q;
  assign done = done_q;
endmodule
